// File: rtl/readout_unit.sv
// Byte FIFO with a debounced-by-edge push button that pops the head entry, and
// four active-low seven-segment displays showing count, read index and head byte.
module readout_unit #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       nnext,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [7:0]             mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [0:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   edge_q, edge_d;
    logic                   armed_q, armed_d;
    logic                   press, pop, do_wr;
    logic [7:0]             head;
    logic [4:0]             cnt_ext;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        sync_d    = sync_q;
        vld_d     = vld_q;
        sync_d[0] = nnext;
        vld_d[0]  = 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
        edge_d  = sync_q[SYNC_STAGES-1];
        // Arm only once a genuine released level has crossed the synchronizer,
        // so a button held through reset cannot fake a press on release.
        armed_d = armed_q | (vld_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1]);
        press   = armed_q & edge_q & ~sync_q[SYNC_STAGES-1];

        pop   = press & (state_q == S_SHOW);
        do_wr = wr_en & (~full | pop);
        ovf_d = ovf_q | (wr_en & full & ~pop);

        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !do_wr)
            count_d = count_q - (AW+1)'(1);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (do_wr) state_d = S_SHOW;
            default: if (pop && !do_wr && count_q == (AW+1)'(1)) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            sync_q   <= '1;
            vld_q    <= '0;
            edge_q   <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            sync_q   <= sync_d;
            vld_q    <= vld_d;
            edge_q   <= edge_d;
            armed_q  <= armed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head    = mem_q[rd_ptr_q];
    assign cnt_ext = 5'(count_q);
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign ovf     = ovf_q;
    assign disp3   = hex7(cnt_ext[4] ? 4'hF : cnt_ext[3:0]);
    assign disp2   = hex7(4'(rd_ptr_q));
    assign disp1   = (state_q == S_SHOW) ? hex7(head[7:4]) : SEG_DASH;
    assign disp0   = (state_q == S_SHOW) ? hex7(head[3:0]) : SEG_DASH;

endmodule

// File: tb/tb_readout_unit.sv
// Directed bench for readout_unit: writes, overflow, button pops, simultaneous
// write+pop, pointer wrap and asynchronous reset with the button held.
module tb_readout_unit;
    logic       clk = 1'b0;
    logic       nreset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       nnext;
    logic       full, empty, ovf;
    logic [6:0] disp3, disp2, disp1, disp0;

    localparam logic [6:0] SEG_DASH = 7'b0111111;

    int total = 0;
    int bad   = 0;
    int rd    = 0;
    logic [7:0] exp_q[$];

    readout_unit #(.DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .nreset(nreset), .wr_en(wr_en), .wr_data(wr_data),
        .nnext(nnext), .full(full), .empty(empty), .ovf(ovf),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (exp_q.size() < 8) exp_q.push_back(b);
    endtask

    // Press: sampled at the first edge, popped two edges later, then released.
    task automatic pop_one();
        nnext = 1'b0;
        idle(3);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            rd = (rd + 1) % 8;
        end
        nnext = 1'b1;
        idle(3);
    endtask

    task automatic check_reset(input string pre);
        check({pre, "_full"},  full,  0);
        check({pre, "_empty"}, empty, 1);
        check({pre, "_ovf"},   ovf,   0);
        check({pre, "_d3"},    disp3, seg_of(4'h0));
        check({pre, "_d2"},    disp2, seg_of(4'h0));
        check({pre, "_d1"},    disp1, SEG_DASH);
        check({pre, "_d0"},    disp0, SEG_DASH);
    endtask

    task automatic check_head(input string pre);
        check({pre, "_d1"}, disp1, seg_of(exp_q[0][7:4]));
        check({pre, "_d0"}, disp0, seg_of(exp_q[0][3:0]));
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        #1;
        exp_q.delete();
        rd = 0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        idle(4);
    endtask

    initial begin
        nreset  = 1'b0;
        nnext   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        #3;
        check_reset("rst");
        @(posedge clk);
        #1;
        nreset = 1'b1;
        idle(4);

        write_byte(8'h3C);
        check("w1_empty", empty, 0);
        check("w1_d3", disp3, seg_of(4'h1));
        check("w1_d2", disp2, seg_of(4'h0));
        check("w1_d1", disp1, seg_of(4'h3));
        check("w1_d0", disp0, seg_of(4'hC));

        do_reset();
        for (int i = 1; i <= 8; i++) write_byte(8'(i * 17));
        check("fill_full", full, 1);
        check("fill_d3", disp3, seg_of(4'h8));
        check("fill_ovf", ovf, 0);
        check_head("fill");
        write_byte(8'h99);
        check("ovf_set", ovf, 1);
        check("ovf_full", full, 1);
        check("ovf_d3", disp3, seg_of(4'h8));
        check("ovf_head", disp0, seg_of(4'h1));

        do_reset();
        check("rst2_ovf", ovf, 0);
        for (int i = 1; i <= 8; i++) write_byte(8'(i * 17));
        nnext = 1'b0;
        idle(2);
        check("hold_n1_d3", disp3, seg_of(4'h8));
        idle(1);
        void'(exp_q.pop_front());
        rd = 1;
        check("hold_pop_d3", disp3, seg_of(4'h7));
        check("hold_pop_d2", disp2, seg_of(4'h1));
        check("hold_pop_d1", disp1, seg_of(4'h2));
        check("hold_pop_d0", disp0, seg_of(4'h2));
        idle(7);
        check("hold_once_d3", disp3, seg_of(4'h7));
        check("hold_once_d2", disp2, seg_of(4'h1));
        nnext = 1'b1;
        idle(3);

        write_byte(8'hC3);
        check("refill_full", full, 1);
        nnext = 1'b0;
        idle(2);
        wr_en   = 1'b1;
        wr_data = 8'hAB;
        idle(1);
        wr_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'hAB);
        rd = 2;
        check("wp_d3", disp3, seg_of(4'h8));
        check("wp_ovf", ovf, 0);
        check("wp_full", full, 1);
        check("wp_d2", disp2, seg_of(4'h2));
        check_head("wp");
        nnext = 1'b1;
        idle(3);

        for (int k = 0; k < 8; k++) begin
            check_head($sformatf("drain%0d", k));
            pop_one();
            check($sformatf("drain%0d_d2", k), disp2, seg_of(4'(rd)));
        end
        check("drain_empty", empty, 1);
        check("drain_d3", disp3, seg_of(4'h0));
        check("drain_d1", disp1, SEG_DASH);

        pop_one();
        check("idle_pop_empty", empty, 1);
        check("idle_pop_d2", disp2, seg_of(4'(rd)));
        check("idle_pop_d1", disp1, SEG_DASH);
        check("idle_pop_d0", disp0, SEG_DASH);

        for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
        check("five_d3", disp3, seg_of(4'h5));
        #2;
        nreset = 1'b0;
        nnext  = 1'b0;
        #1;
        exp_q.delete();
        rd = 0;
        check_reset("async");
        idle(2);
        nreset = 1'b1;
        idle(6);
        write_byte(8'h5A);
        idle(6);
        check("held_d3", disp3, seg_of(4'h1));
        check_head("held");
        nnext = 1'b1;
        idle(3);
        pop_one();
        check("final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
